chan_scan_mux: RTL and testbench
================================

CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 The block SHALL have localparam SEL_W = clog2(CHANNELS), channel index width.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port: in_valid  input  CHANNELS  per-channel data valid.
REQ-008 Port: in_ready  output  CHANNELS  per-channel accept strobe.
REQ-009 Port: mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-010 Port: sel  input  SEL_W  channel chosen in fixed mode.
REQ-011 Port: out_data  output  WIDTH  registered selected data.
REQ-012 Port: out_chan  output  SEL_W  index of channel that supplied out_data.
REQ-013 Port: out_valid  output  1  out_data holds an unconsumed word.
REQ-014 Port: out_ready  input  1  downstream accepts word when high with out_valid.

Function
REQ-015 Output stage SHALL be one register with FSM states EMPTY and FULL.
REQ-016 load_en SHALL be (state==EMPTY) or (out_valid and out_ready).
REQ-017 Transfer in channel i SHALL occur when in_valid[i] and in_ready[i]; in_ready[i] = grant[i] and load_en, combinational, one-hot or zero.
REQ-018 Fixed mode SHALL grant channel sel only; sel >= CHANNELS SHALL grant nothing.
REQ-019 Scan mode SHALL grant the first valid channel at or after ptr, wrapping CHANNELS-1 -> 0.
REQ-020 After a scan-mode grant of channel g, ptr SHALL become (g+1) mod CHANNELS; ptr SHALL not change without a grant.
REQ-021 Latency SHALL be one cycle: data accepted at edge N appears on out_data/out_chan with out_valid=1 after edge N.
REQ-022 EMPTY->FULL on grant; FULL->EMPTY on consume without grant; FULL->FULL on consume with grant (back-to-back, full throughput) or on stall.
REQ-023 While FULL and out_ready=0, out_data/out_chan SHALL hold and all in_ready SHALL be 0.
REQ-024 mode or sel changes SHALL take effect on the next grant decision only; a held word SHALL never be altered.
REQ-025 Fixed mode SHALL not modify ptr.

Reset
REQ-026 On rst_n=0, asynchronously: state=EMPTY, out_valid=0, out_data=0, out_chan=0, ptr=0, parity output 0 if present.
REQ-027 Reset mid-transfer SHALL discard the held word; first grant after release SHALL use ptr=0.

Configuration
REQ-028 Macro CHAN_SCAN_PARITY_EN defined: port out_parity (output, 1) SHALL be registered even parity (XOR) of out_data, updated with it.
REQ-029 Macro not defined: out_parity port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package chan_scan_pkg SHALL hold mode constants (MODE_FIXED=0, MODE_SCAN=1) and state encoding (EMPTY=0, FULL=1).
REQ-031 Sub-module rr_arbiter (parameter CHANNELS; inputs req, ptr; output one-hot grant) SHALL implement REQ-019.

Verification
REQ-032 Reset then mode=0, sel=3, in_data ch0..3 = 0x01,0x03,0x07,0x0F, all valid, out_ready=1 -> out_data=0x0F, out_chan=3 one cycle later; in_ready=4'b1000.
REQ-033 mode=1, all four valid, out_ready=1 -> out_chan sequence 0,1,2,3,0, out_data 0x01,0x03,0x07,0x0F,0x01, one word per cycle.
REQ-034 mode=1, in_valid=4'b0101 -> out_chan alternates 0,2,0; channels 1 and 3 never see in_ready.
REQ-035 FULL with out_data=0x07, out_ready=0 for 5 cycles -> out_data=0x07 held, in_ready=0; out_ready=1 then next word accepted same cycle.
REQ-036 rst_n pulsed low while FULL mid-scan (ptr=2) -> out_valid=0 immediately; after release first grant is ch0.
REQ-037 With CHAN_SCAN_PARITY_EN, out_data=0x07 -> out_parity=1; out_data=0x0F -> out_parity=0.

Source files
------------

// File: rtl/chan_scan_pkg.sv
// Shared constants for the channel scan multiplexer:
// mode select values and output-stage state encoding.
package chan_scan_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SCAN  = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/chan_scan_mux_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first
// requesting channel at or after ptr, wrapping to channel 0.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] grant
);

    logic w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!w_found && req[(int'(ptr) + k) % CHANNELS]) begin
                grant[(int'(ptr) + k) % CHANNELS] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// Channel multiplexer (fixed select or round-robin scan) into a
// one-word output register. CHAN_SCAN_PARITY_EN adds out_parity.
module chan_scan_mux
    import chan_scan_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef CHAN_SCAN_PARITY_EN
    ,
    output logic                      out_parity
`endif
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_chan;
    logic [WIDTH-1:0]    r_data;
    logic [SEL_W-1:0]    w_ptr_nxt;
    logic [SEL_W-1:0]    w_gidx;
    logic [WIDTH-1:0]    w_sel_data;
    logic [CHANNELS-1:0] w_arb_grant;
    logic [CHANNELS-1:0] w_fix_grant;
    logic [CHANNELS-1:0] w_grant;
    logic                w_load_en;
    logic                w_xfer;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req   (in_valid),
        .ptr   (r_ptr),
        .grant (w_arb_grant)
    );

    // An out-of-range sel matches no channel and grants nothing.
    always_comb begin
        w_fix_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel) == i) w_fix_grant[i] = 1'b1;
        end
    end

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) w_gidx = SEL_W'(i);
        end
    end

    assign w_grant    = (mode == MODE_SCAN) ? w_arb_grant : w_fix_grant;
    assign w_load_en  = (r_state == EMPTY) || out_ready;
    assign in_ready   = w_load_en ? w_grant : '0;
    assign w_xfer     = |(in_ready & in_valid);
    assign w_sel_data = in_data[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_ptr_nxt  = (int'(w_gidx) == CHANNELS - 1) ? '0
                      : w_gidx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY:   if (w_xfer) w_state_nxt = FULL;
            FULL:    if (out_ready && !w_xfer) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_chan  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_data <= w_sel_data;
                r_chan <= w_gidx;
                if (mode == MODE_SCAN) r_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef CHAN_SCAN_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_xfer) begin
            r_parity <= ^w_sel_data;
        end
    end

    assign out_parity = r_parity;
`endif

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = (r_state == FULL);

endmodule

// File: tb/tb_chan_scan_mux.sv
// Self-checking bench for chan_scan_mux: directed vector table,
// reset-mid-scan sequence, then randomized traffic vs a model.
module tb_chan_scan_mux;

    localparam int W  = 8;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   in_data;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic          mode;
    logic [1:0]    sel;
    logic [7:0]    out_data;
    logic [1:0]    out_chan;
    logic          out_valid;
    logic          out_ready;
`ifdef CHAN_SCAN_PARITY_EN
    logic          out_parity;
`endif

    chan_scan_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CHAN_SCAN_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: what the output register should hold.
    bit         m_full;
    logic [7:0] m_data;
    int         m_chan;
    int         m_ptr;
    logic [3:0] got_rdy;
    logic [3:0] exp_rdy;

    localparam logic [31:0] DATA4 = 32'h0F07_0301;

    typedef struct {
        logic       m;
        logic [1:0] s;
        logic [3:0] v;
        logic       o;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] ch;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] g;
        g = '0;
        if (m_full && !out_ready) return '0;
        if (mode == 1'b0) begin
            if (int'(sel) < CH) g[sel] = 1'b1;
        end else begin
            for (int k = 0; k < CH; k++) begin
                int idx;
                idx = (m_ptr + k) % CH;
                if (in_valid[idx]) begin
                    g[idx] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    task automatic model_edge(input logic [3:0] r);
        int idx;
        idx = -1;
        for (int i = 0; i < CH; i++)
            if (r[i] && in_valid[i]) idx = i;
        if (idx >= 0) begin
            m_data = in_data[idx*W +: W];
            m_chan = idx;
            m_full = 1'b1;
            if (mode) m_ptr = (idx + 1) % CH;
        end else if (m_full && out_ready) begin
            m_full = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_chan = 0;
        m_ptr  = 0;
    endtask

    task automatic apply(input logic m, input logic [1:0] s,
                         input logic [3:0] v, input logic o,
                         input logic [31:0] d);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = o;
        in_data   = d;
        @(negedge clk);
        got_rdy = in_ready;
        exp_rdy = model_ready();
        @(posedge clk);
        model_edge(exp_rdy);
        #1;
    endtask

    task automatic pulse_reset(input string nm);
        rst_n = 1'b0;
        #1;
        chk({nm, "_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_data"}, 32'(out_data), 32'd0);
        chk({nm, "_chan"}, 32'(out_chan), 32'd0);
`ifdef CHAN_SCAN_PARITY_EN
        chk({nm, "_parity"}, 32'(out_parity), 32'd0);
`endif
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h0F};
        tbl[1]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01};
        tbl[2]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h03};
        tbl[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h07};
        tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h0F};
        tbl[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01};
        tbl[6]  = '{1'b1, 2'd0, 4'h5, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h07};
        tbl[7]  = '{1'b1, 2'd0, 4'h5, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01};
        tbl[8]  = '{1'b1, 2'd0, 4'h5, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h07};
        for (int i = 9; i < 14; i++)
            tbl[i] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h07};
        tbl[14] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h0F};
        tbl[15] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h0F};
        tbl[16] = '{1'b0, 2'd1, 4'h0, 1'b1, 4'b0010, 1'b0, 2'd3, 8'h0F};
        tbl[17] = '{1'b0, 2'd1, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h03};
        tbl[18] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h03};
        tbl[19] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01};

        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'h0;
        out_ready = 1'b0;
        in_data   = DATA4;
        model_reset();
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_chan", 32'(out_chan), 32'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].o, DATA4);
            chk($sformatf("vec%0d_ready", i), 32'(got_rdy), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d_chan", i), 32'(out_chan), 32'(tbl[i].ch));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].d));
`ifdef CHAN_SCAN_PARITY_EN
            chk($sformatf("vec%0d_parity", i), 32'(out_parity),
                32'(^tbl[i].d));
`endif
        end

        // ptr is 1 here; grant ch1 so ptr becomes 2, then reset while FULL.
        apply(1'b1, 2'd0, 4'hF, 1'b1, DATA4);
        chk("pre_rst_chan", 32'(out_chan), 32'd1);
        pulse_reset("midrst");
        apply(1'b1, 2'd0, 4'hF, 1'b1, DATA4);
        chk("post_rst_ready", 32'(got_rdy), 32'b0001);
        chk("post_rst_chan", 32'(out_chan), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'h01);

        for (int c = 0; c < 400; c++) begin
            apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  $urandom());
            chk($sformatf("rnd%0d_ready", c), 32'(got_rdy), 32'(exp_rdy));
            chk($sformatf("rnd%0d_valid", c), 32'(out_valid), 32'(m_full));
            chk($sformatf("rnd%0d_chan", c), 32'(out_chan), 32'(m_chan));
            chk($sformatf("rnd%0d_data", c), 32'(out_data), 32'(m_data));
`ifdef CHAN_SCAN_PARITY_EN
            chk($sformatf("rnd%0d_parity", c), 32'(out_parity),
                32'(^m_data));
`endif
            if ($urandom_range(0, 49) == 0) pulse_reset("rndrst");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
